// File: rtl/pll_clken_gen.sv
// pll_clken_gen -- runtime-programmable multi-channel clock-enable / duty-level generator
// Revision 1.0
`default_nettype none

module pll_clken_gen #(
  parameter int NUM_CLOCKS  = 4,
  parameter int DIV_W       = 16,
  parameter int LOCK_CYCLES = 64,
  parameter int DEFAULT_DIV = 2,
  parameter int CHAN_W      = 2
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [CHAN_W-1:0]     cfg_chan,
  input  logic [DIV_W-1:0]      cfg_div,
  input  logic [DIV_W-1:0]      cfg_high,
  input  logic [DIV_W-1:0]      cfg_phase,
  output logic [NUM_CLOCKS-1:0] outclk,
  output logic [NUM_CLOCKS-1:0] outclk_en,
  output logic                  locked
);

  localparam int                LOCK_W    = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);
  localparam logic [LOCK_W-1:0] LOCK_ONE  = LOCK_W'(1);
  localparam logic [DIV_W-1:0]  RST_DIV   = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0]  RST_HIGH  = DIV_W'(DEFAULT_DIV / 2);
  localparam logic [DIV_W-1:0]  ONE       = DIV_W'(1);

  typedef enum logic [1:0] {
    RESTART  = 2'd0,
    LOCKING  = 2'd1,
    LOCKED   = 2'd2,
    RECONFIG = 2'd3
  } state_t;

  state_t             state;
  logic [LOCK_W-1:0]  lock_cnt;
  logic [DIV_W-1:0]   div_q   [NUM_CLOCKS];
  logic [DIV_W-1:0]   high_q  [NUM_CLOCKS];
  logic [DIV_W-1:0]   phase_q [NUM_CLOCKS];
  logic [DIV_W-1:0]   cnt     [NUM_CLOCKS];
  logic [DIV_W-1:0]   cnt_nxt [NUM_CLOCKS];
  logic               chan_ok;
  logic               wr;

  assign chan_ok = (32'(cfg_chan) < NUM_CLOCKS);
  // Out-of-range channel writes complete the handshake but change nothing.
  assign wr      = cfg_valid && cfg_ready && chan_ok;

  // cfg_ready and locked are registered alongside the state they describe.
  always_ff @(posedge refclk) begin
    if (!rst) begin
      state     <= RESTART;
      lock_cnt  <= '0;
      cfg_ready <= 1'b0;
      locked    <= 1'b0;
    end else begin
      case (state)
        RESTART: begin
          state     <= LOCKING;
          lock_cnt  <= '0;
          cfg_ready <= 1'b1;
          locked    <= 1'b0;
        end
        LOCKING: begin
          if (wr) begin
            state     <= RECONFIG;
            cfg_ready <= 1'b0;
            locked    <= 1'b0;
          end else if (lock_cnt == LOCK_LAST) begin
            state  <= LOCKED;
            locked <= 1'b1;
          end else begin
            lock_cnt <= lock_cnt + LOCK_ONE;
          end
        end
        LOCKED: begin
          if (wr) begin
            state     <= RECONFIG;
            cfg_ready <= 1'b0;
            locked    <= 1'b0;
          end
        end
        RECONFIG: begin
          state     <= RESTART;
          cfg_ready <= 1'b0;
          locked    <= 1'b0;
        end
        default: begin
          state     <= RESTART;
          cfg_ready <= 1'b0;
          locked    <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge refclk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CLOCKS; i++) begin
        div_q[i]   <= RST_DIV;
        high_q[i]  <= RST_HIGH;
        phase_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CLOCKS; i++) begin
        if (wr && (cfg_chan == CHAN_W'(i))) begin
          div_q[i]   <= cfg_div;
          high_q[i]  <= cfg_high;
          phase_q[i] <= cfg_phase;
        end
      end
    end
  end

  // Counter wraps on >= so a counter left beyond a freshly shrunk divide
  // ratio (during RECONFIG) returns to 0 instead of running away.
  always_comb begin
    for (int i = 0; i < NUM_CLOCKS; i++) begin
      if (state == RESTART) begin
        if ((phase_q[i] != '0) && (phase_q[i] < div_q[i])) begin
          cnt_nxt[i] = div_q[i] - phase_q[i];
        end else begin
          cnt_nxt[i] = '0;
        end
      end else if ((div_q[i] == '0) || (cnt[i] >= div_q[i] - ONE)) begin
        cnt_nxt[i] = '0;
      end else begin
        cnt_nxt[i] = cnt[i] + ONE;
      end
    end
  end

  // Outputs are derived from the counter value of the coming cycle so that
  // the first cycle after RESTART already shows step 0.
  always_ff @(posedge refclk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CLOCKS; i++) begin
        cnt[i] <= '0;
      end
      outclk    <= '0;
      outclk_en <= '0;
    end else begin
      for (int i = 0; i < NUM_CLOCKS; i++) begin
        cnt[i]       <= cnt_nxt[i];
        outclk_en[i] <= (div_q[i] != '0) && (cnt_nxt[i] == '0);
        outclk[i]    <= (div_q[i] != '0) && (cnt_nxt[i] < high_q[i]);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pll_clken_gen.sv
// tb_pll_clken_gen -- randomized, model-checked bench for pll_clken_gen
// Revision 1.0
`default_nettype none

module tb_pll_clken_gen;

  localparam int NC   = 3;
  localparam int DW   = 16;
  localparam int LOCK = 64;
  localparam int DDIV = 2;
  localparam int CW   = 2;

  logic          refclk = 1'b0;
  logic          rst;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [CW-1:0] cfg_chan;
  logic [DW-1:0] cfg_div;
  logic [DW-1:0] cfg_high;
  logic [DW-1:0] cfg_phase;
  logic [NC-1:0] outclk;
  logic [NC-1:0] outclk_en;
  logic          locked;

  always #5 refclk = ~refclk;

  pll_clken_gen #(
    .NUM_CLOCKS (NC),
    .DIV_W      (DW),
    .LOCK_CYCLES(LOCK),
    .DEFAULT_DIV(DDIV),
    .CHAN_W     (CW)
  ) dut (
    .refclk   (refclk),
    .rst      (rst),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_chan (cfg_chan),
    .cfg_div  (cfg_div),
    .cfg_high (cfg_high),
    .cfg_phase(cfg_phase),
    .outclk   (outclk),
    .outclk_en(outclk_en),
    .locked   (locked)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Model: per = index of the current cycle, rs = index of the last RESTART cycle.
  int per    = 0;
  int rs     = 0;
  bit rs_rst = 1'b0;
  bit mvalid = 1'b0;
  int m_div   [NC];
  int m_high  [NC];
  int m_phase [NC];

  function automatic bit ready_exp(int t);
    return mvalid && (t > rs);
  endfunction

  function automatic bit locked_exp(int t);
    return mvalid && (t >= rs + LOCK + 1);
  endfunction

  // Position within the period at step k, or -1 for a disabled channel.
  function automatic int pos(int i, int k);
    int start;
    if (m_div[i] == 0) return -1;
    start = (m_phase[i] < m_div[i]) ? (m_div[i] - m_phase[i]) % m_div[i] : 0;
    return (start + k) % m_div[i];
  endfunction

  function automatic logic [31:0] en_exp(int k);
    logic [31:0] v = '0;
    for (int i = 0; i < NC; i++) v[i] = (pos(i, k) == 0);
    return v;
  endfunction

  function automatic logic [31:0] clk_exp(int k);
    logic [31:0] v = '0;
    for (int i = 0; i < NC; i++) v[i] = (pos(i, k) >= 0) && (pos(i, k) < m_high[i]);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, per);
  endtask

  task automatic model_edge();
    int p = per;
    if (!rst) begin
      for (int i = 0; i < NC; i++) begin
        m_div[i] = DDIV; m_high[i] = DDIV / 2; m_phase[i] = 0;
      end
      rs = p + 1; rs_rst = 1'b1; mvalid = 1'b1;
    end else if (ready_exp(p) && cfg_valid && (int'(cfg_chan) < NC)) begin
      m_div[cfg_chan]   = int'(cfg_div);
      m_high[cfg_chan]  = int'(cfg_high);
      m_phase[cfg_chan] = int'(cfg_phase);
      rs = p + 2; rs_rst = 1'b0;
    end
    per = p + 1;
  endtask

  task automatic tick();
    @(posedge refclk);
    model_edge();
    #1;
  endtask

  task automatic wr(input int ch, input int d, input int h, input int ph);
    cfg_chan  = CW'(ch);
    cfg_div   = DW'(d);
    cfg_high  = DW'(h);
    cfg_phase = DW'(ph);
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_locked();
    while (per < rs + LOCK + 1) tick();
  endtask

  always @(negedge refclk) begin
    if (mvalid) begin
      check("cfg_ready", 32'(cfg_ready), 32'(ready_exp(per)));
      check("locked", 32'(locked), 32'(locked_exp(per)));
      if (per > rs) begin
        check("outclk_en", 32'(outclk_en), en_exp(per - rs - 1));
        check("outclk", 32'(outclk), clk_exp(per - rs - 1));
      end else if ((per == rs) && rs_rst) begin
        check("outclk_en_rst", 32'(outclk_en), 32'd0);
        check("outclk_rst", 32'(outclk), 32'd0);
      end
    end
  end

  initial begin
    int en_pat [6] = '{1, 0, 0, 0, 0, 1};
    int ck_pat [6] = '{1, 1, 0, 0, 0, 1};
    rst = 1'b0; cfg_valid = 1'b0; cfg_chan = '0;
    cfg_div = '0; cfg_high = '0; cfg_phase = '0;

    // Reset and default-divide start-up
    tick();
    check("rst_outclk", 32'(outclk), 32'd0);
    check("rst_en", 32'(outclk_en), 32'd0);
    check("rst_ready", 32'(cfg_ready), 32'd0);
    rst = 1'b1;
    tick();
    check("s0_en", 32'(outclk_en), 32'h7);
    check("s0_clk", 32'(outclk), 32'h7);
    check("s0_ready", 32'(cfg_ready), 32'd1);
    tick();
    check("s1_en", 32'(outclk_en), 32'h0);
    check("s1_clk", 32'(outclk), 32'h0);
    while (per < rs + LOCK) tick();
    check("lock_64", 32'(locked), 32'd0);
    tick();
    check("lock_65", 32'(locked), 32'd1);

    // ch1 div=5 high=2
    wr(1, 5, 2, 0);
    check("reconf_locked", 32'(locked), 32'd0);
    check("reconf_ready", 32'(cfg_ready), 32'd0);
    tick();
    check("restart_ready", 32'(cfg_ready), 32'd0);
    tick();
    check("realign_ch0", 32'(outclk_en[0]), 32'd1);
    for (int s = 0; s < 6; s++) begin
      check("ch1_en", 32'(outclk_en[1]), 32'(en_pat[s]));
      check("ch1_clk", 32'(outclk[1]), 32'(ck_pat[s]));
      tick();
    end

    // Phase offset, then phase >= div
    wait_locked();
    wr(2, 4, 2, 1); tick(); tick();
    check("ph1_s0_en0", 32'(outclk_en[0]), 32'd1);
    check("ph1_s0_en2", 32'(outclk_en[2]), 32'd0);
    tick();
    check("ph1_s1_en0", 32'(outclk_en[0]), 32'd0);
    check("ph1_s1_en2", 32'(outclk_en[2]), 32'd1);
    wait_locked();
    wr(2, 4, 2, 7); tick(); tick();
    check("ph7_en2", 32'(outclk_en[2]), 32'd1);
    check("ph7_clk2", 32'(outclk[2]), 32'd1);

    // Boundary divides on ch2
    wr(2, 0, 0, 0); tick(); tick();
    check("div0_en", 32'(outclk_en[2]), 32'd0);
    check("div0_clk", 32'(outclk[2]), 32'd0);
    wr(2, 1, 0, 0); tick(); tick();
    check("div1_en", 32'(outclk_en[2]), 32'd1);
    check("div1_clk", 32'(outclk[2]), 32'd0);
    tick();
    check("div1_en_b", 32'(outclk_en[2]), 32'd1);
    wr(2, 3, 9, 0); tick(); tick();
    for (int s = 0; s < 3; s++) begin
      check("hi_ge_div", 32'(outclk[2]), 32'd1);
      tick();
    end

    // Out-of-range channel, then abort of a lock count
    wait_locked();
    wr(3, 5, 1, 0);
    check("badch_ready", 32'(cfg_ready), 32'd1);
    check("badch_locked", 32'(locked), 32'd1);
    wr(1, 2, 1, 0); tick(); tick();
    while (per < rs + 31) tick();
    wr(0, 2, 1, 0);
    while (per < rs + LOCK) tick();
    check("abort_64", 32'(locked), 32'd0);
    tick();
    check("abort_65", 32'(locked), 32'd1);

    // Reset colliding with a config write
    cfg_chan = CW'(1); cfg_div = DW'(7); cfg_high = DW'(3); cfg_phase = '0;
    cfg_valid = 1'b1; rst = 1'b0;
    tick();
    rst = 1'b1; cfg_valid = 1'b0;
    check("rstw_clk", 32'(outclk), 32'd0);
    check("rstw_locked", 32'(locked), 32'd0);
    tick();
    check("rstw_en", 32'(outclk_en), 32'h7);
    check("rstw_clk_s0", 32'(outclk), 32'h7);

    // Randomized traffic
    for (int it = 0; it < 60; it++) begin
      int idle = $urandom_range(0, 90);
      for (int j = 0; j < idle; j++) tick();
      if ($urandom_range(0, 19) == 0) begin
        rst = 1'b0;
        cfg_valid = $urandom_range(0, 1) == 1;
        repeat ($urandom_range(1, 2)) tick();
        rst = 1'b1; cfg_valid = 1'b0;
      end else begin
        int burst = $urandom_range(1, 3);
        for (int b = 0; b < burst; b++)
          wr($urandom_range(0, 3), $urandom_range(0, 9), $urandom_range(0, 10), $urandom_range(0, 10));
      end
    end
    repeat (80) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
